// File: rtl/phy_link_monitor.sv
// Periodic PHY status poller: reads the BMSR through the MDIO unit's req/ready handshake,
// debounces the link bit into link_up and raises sticky link-change / timeout flags.
module phy_link_monitor #(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [4:0]  STATUS_REG    = 5'd1,
    parameter logic [15:0] POLL_INTERVAL = 16'd50000,
    parameter int          DEBOUNCE      = 3,
    parameter logic [15:0] TIMEOUT       = 16'd4096
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        enable,
    output logic        md_req,
    output logic        md_rw,
    output logic [4:0]  md_phy_addr,
    output logic [4:0]  md_reg_addr,
    input  logic        md_ready,
    input  logic [15:0] md_rdata,
    input  logic        irq_clear,
    output logic        link_up,
    output logic        link_irq,
    output logic        timeout_err,
    output logic [15:0] status_q,
    output logic [1:0]  dbg_state
);

    // Handshake: md_req rises on REQ entry and stays high until the cycle in which
    // md_ready is sampled high (or the timeout expires); md_ready elsewhere is ignored.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EVAL = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  deb_q, deb_d;
    logic [15:0] status_d;
    logic        md_req_q, md_req_d;
    logic        link_up_q, link_up_d;
    logic        link_irq_q, link_irq_d;
    logic        timeout_err_q, timeout_err_d;
    logic        link_set, to_set;
    logic [3:0]  deb_inc;

    assign deb_inc = deb_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        deb_d    = deb_q;
        status_d = status_q;
        link_up_d = link_up_q;
        link_set = 1'b0;
        to_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_REQ;
            end
            S_REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (md_ready) begin
                    status_d = md_rdata;
                    state_d  = S_EVAL;
                end else if (cnt_q == TIMEOUT - 16'd1) begin
                    to_set  = 1'b1;
                    state_d = enable ? S_WAIT : S_IDLE;
                end
            end
            S_EVAL: begin
                if (status_q[2] == link_up_q) begin
                    deb_d = 4'd0;
                end else if (deb_inc == DEB_LIMIT) begin
                    link_up_d = ~link_up_q;
                    link_set  = 1'b1;
                    deb_d     = 4'd0;
                end else begin
                    deb_d = deb_inc;
                end
                state_d = enable ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == POLL_INTERVAL - 16'd1) state_d = enable ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Every state starts its cycle count from zero.
        if (state_d != state_q) cnt_d = 16'd0;
        md_req_d      = (state_d == S_REQ);
        link_irq_d    = link_set | (link_irq_q & ~irq_clear);
        timeout_err_d = to_set | (timeout_err_q & ~irq_clear);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 16'd0;
            deb_q         <= 4'd0;
            status_q      <= 16'h0000;
            md_req_q      <= 1'b0;
            link_up_q     <= 1'b0;
            link_irq_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            deb_q         <= deb_d;
            status_q      <= status_d;
            md_req_q      <= md_req_d;
            link_up_q     <= link_up_d;
            link_irq_q    <= link_irq_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign md_req      = md_req_q;
    assign md_rw       = 1'b1;
    assign md_phy_addr = PHY_ADDR;
    assign md_reg_addr = STATUS_REG;
    assign link_up     = link_up_q;
    assign link_irq    = link_irq_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_phy_link_monitor.sv
// Bench for phy_link_monitor: a responder answers polls, a status scoreboard and a
// small debounce model predict status_q, link_up and the sticky flags.
module tb_phy_link_monitor;

    localparam int DB = 3;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        md_ready = 1'b0;
    logic [15:0] md_rdata = 16'h0000;
    logic        irq_clear = 1'b0;
    logic        md_req, md_rw, link_up, link_irq, timeout_err;
    logic [4:0]  md_phy_addr, md_reg_addr;
    logic [15:0] status_q;
    logic [1:0]  dbg_state;

    phy_link_monitor #(
        .PHY_ADDR(5'd1), .STATUS_REG(5'd1), .POLL_INTERVAL(16'd16),
        .DEBOUNCE(DB), .TIMEOUT(16'd64)
    ) dut (
        .clk_in(clk_in), .reset_n(reset_n), .enable(enable),
        .md_req(md_req), .md_rw(md_rw), .md_phy_addr(md_phy_addr),
        .md_reg_addr(md_reg_addr), .md_ready(md_ready), .md_rdata(md_rdata),
        .irq_clear(irq_clear), .link_up(link_up), .link_irq(link_irq),
        .timeout_err(timeout_err), .status_q(status_q), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // scoreboard and reference model
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic        m_link = 1'b0;
    logic        m_irq = 1'b0;
    int          m_deb = 0;
    logic [15:0] m_status = 16'h0000;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    // driver tasks
    task automatic wait_req(output int ok, output int rise_cyc);
        int n = 0;
        while (md_req !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        ok = (md_req === 1'b1);
        rise_cyc = cyc;
        if (!ok) check_eq("req_wait", 16'(md_req), 16'd1);
    endtask

    task automatic respond(input logic [15:0] data, input int lat, input bit clr_eval,
                           output int rise_cyc);
        int   ok;
        logic set;
        wait_req(ok, rise_cyc);
        if (ok == 0) return;
        repeat (lat) tick();
        md_ready = 1'b1;
        md_rdata = data;
        exp_q.push_back(data);
        set = 1'b0;
        if (data[2] == m_link) begin
            m_deb = 0;
        end else begin
            m_deb++;
            if (m_deb == DB) begin
                m_link = ~m_link;
                m_deb  = 0;
                set    = 1'b1;
            end
        end
        tick();
        md_ready = 1'b0;
        md_rdata = 16'($urandom_range(0, 65535));
        check_eq("req_drop", 16'(md_req), 16'd0);
        check_eq("status", status_q, exp_q.pop_front());
        m_status = data;
        if (clr_eval) irq_clear = 1'b1;
        if (set) m_irq = 1'b1;
        else if (clr_eval) m_irq = 1'b0;
        tick();
        irq_clear = 1'b0;
        check_eq("link_up", 16'(link_up), 16'(m_link));
        check_eq("link_irq", 16'(link_irq), 16'(m_irq));
    endtask

    task automatic pulse_clear();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
    endtask

    initial begin
        int r0, r1, ok, n;
        repeat (3) tick();
        check_eq("rst_md_req", 16'(md_req), 16'd0);
        check_eq("rst_link_up", 16'(link_up), 16'd0);
        check_eq("rst_link_irq", 16'(link_irq), 16'd0);
        check_eq("rst_timeout", 16'(timeout_err), 16'd0);
        check_eq("rst_status", status_q, 16'h0000);
        check_eq("md_rw", 16'(md_rw), 16'd1);
        check_eq("phy_addr", 16'(md_phy_addr), 16'd1);
        check_eq("reg_addr", 16'(md_reg_addr), 16'd1);
        reset_n = 1'b1;
        tick();
        check_eq("idle_no_req", 16'(md_req), 16'd0);
        enable = 1'b1;
        tick();
        check_eq("en_to_req", 16'(md_req), 16'd1);

        // link-up debounce, plus poll period with immediate responses
        respond(16'h7849, 0, 1'b0, r0);
        respond(16'h7849, 0, 1'b0, r1);
        check_eq("poll_period", 16'(r1 - r0), 16'd18);
        for (int i = 0; i < 3; i++) respond(16'h786D, $urandom_range(0, 4), 1'b0, r0);
        pulse_clear();
        m_irq = 1'b0;
        check_eq("irq_cleared", 16'(link_irq), 16'd0);

        // glitch rejection, then a drop whose flag set collides with irq_clear
        respond(16'h7849, $urandom_range(0, 4), 1'b0, r0);
        respond(16'h7849, $urandom_range(0, 4), 1'b0, r0);
        respond(16'h786D, $urandom_range(0, 4), 1'b0, r0);
        respond(16'h7849, $urandom_range(0, 4), 1'b0, r0);
        respond(16'h7849, $urandom_range(0, 4), 1'b0, r0);
        respond(16'h7849, $urandom_range(0, 4), 1'b1, r0);

        // stray md_ready while waiting between polls
        md_ready = 1'b1;
        md_rdata = 16'hFFFF;
        tick();
        md_ready = 1'b0;
        tick();
        check_eq("stray_ready", status_q, m_status);

        // timeout: no response at all
        wait_req(ok, r0);
        n = 0;
        while (md_req === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq("req_high_len", 16'(n), 16'd64);
        check_eq("timeout_err", 16'(timeout_err), 16'd1);
        check_eq("to_status", status_q, m_status);
        check_eq("to_link_up", 16'(link_up), 16'(m_link));
        n = 0;
        while (md_req !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq("to_gap", 16'(n), 16'd16);
        respond(16'h7849, 2, 1'b0, r0);
        pulse_clear();
        m_irq = 1'b0;
        check_eq("lone_clr_irq", 16'(link_irq), 16'd0);
        check_eq("lone_clr_to", 16'(timeout_err), 16'd0);

        // enable dropped mid-request
        wait_req(ok, r0);
        enable = 1'b0;
        repeat (10) tick();
        check_eq("req_held", 16'(md_req), 16'd1);
        md_ready = 1'b1;
        md_rdata = 16'h786D;
        exp_q.push_back(16'h786D);
        m_deb++;
        tick();
        md_ready = 1'b0;
        check_eq("drop_req_low", 16'(md_req), 16'd0);
        check_eq("drop_status", status_q, exp_q.pop_front());
        m_status = 16'h786D;
        tick();
        check_eq("drop_link", 16'(link_up), 16'(m_link));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_req === 1'b1) n++;
            tick();
        end
        check_eq("idle_no_poll", 16'(n), 16'd0);
        check_eq("idle_state", 16'(dbg_state), 16'd0);
        enable = 1'b1;
        tick();
        check_eq("reen_req", 16'(md_req), 16'd1);

        // asynchronous reset in the middle of a request
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("arst_md_req", 16'(md_req), 16'd0);
        check_eq("arst_link_up", 16'(link_up), 16'd0);
        check_eq("arst_link_irq", 16'(link_irq), 16'd0);
        check_eq("arst_timeout", 16'(timeout_err), 16'd0);
        check_eq("arst_status", status_q, 16'h0000);
        m_link = 1'b0;
        m_irq = 1'b0;
        m_deb = 0;
        m_status = 16'h0000;
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("post_rst_req", 16'(md_req), 16'd1);
        respond(16'h786D, 1, 1'b0, r0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
